// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

   localparam int unsigned REG_IDX_W       = 5;
   localparam int unsigned WAIT_CNT_W      = 8;
   localparam int unsigned PERF_CNT_W      = 32;
   localparam int unsigned DEFAULT_TIMEOUT = 255;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   // Per-cycle pipeline control bundle driven to the stage registers
   typedef struct packed {
      logic mem_req;
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_flush;
      logic exmem_we;
      logic memwb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = '{
      mem_req: 1'b0, pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
      idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1, memwb_bubble: 1'b0
   };

   localparam ctrl_t CTRL_RESET = '{
      mem_req: 1'b0, pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
      idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0, memwb_bubble: 1'b1
   };

endpackage

// File: rtl/pipe_stall_ctrl_hazard.sv
// Load-use hazard comparator between the ID/EX load and the IF/ID sources.
module hazard_detect
   import pipe_stall_ctrl_pkg::*;
(
   input  logic                 memread_ex_i,
   input  logic [REG_IDX_W-1:0] rd_ex_i,
   input  logic [REG_IDX_W-1:0] rs1_id_i,
   input  logic [REG_IDX_W-1:0] rs2_id_i,
   output logic                 load_use_o
);

   logic w_rd_nonzero;
   logic w_src_match;

   assign w_rd_nonzero = (rd_ex_i != '0);
   assign w_src_match  = (rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i);
   assign load_use_o   = memread_ex_i && w_rd_nonzero && w_src_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, load-use and branch flush.
// Optional perf counters (stall_cnt_o, flush_cnt_o) with `define PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  memread_ex_i,
   input  logic [REG_IDX_W-1:0]  rd_ex_i,
   input  logic [REG_IDX_W-1:0]  rs1_id_i,
   input  logic [REG_IDX_W-1:0]  rs2_id_i,
   input  logic                  branch_taken_i,
   input  logic                  mem_access_i,
   input  logic                  mem_ack_i,
   output logic                  mem_req_o,
   output logic                  pc_we_o,
   output logic                  ifid_we_o,
   output logic                  ifid_flush_o,
   output logic                  idex_we_o,
   output logic                  idex_flush_o,
   output logic                  exmem_we_o,
   output logic                  memwb_bubble_o,
   output logic                  err_o
`ifdef PIPE_STALL_CTRL_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt_o,
   output logic [PERF_CNT_W-1:0] flush_cnt_o
`endif
);

   // Last counter value before the wait counter reaches TIMEOUT
   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
   logic                  r_err;
   logic                  w_err_nxt;
   logic                  w_load_use;
   logic                  w_mem_req;
   logic                  w_mem_stall;
   ctrl_t                 w_ctrl;

   hazard_detect u_hazard_detect (
      .memread_ex_i (memread_ex_i),
      .rd_ex_i      (rd_ex_i),
      .rs1_id_i     (rs1_id_i),
      .rs2_id_i     (rs2_id_i),
      .load_use_o   (w_load_use)
   );

   // State, wait counter and sticky error register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Next state plus prioritised controls: reset > memory stall > load-use > branch
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_err_nxt      = r_err;
      w_mem_req      = 1'b0;
      w_mem_stall    = 1'b0;
      w_ctrl         = CTRL_RUN;

      unique case (r_state)
         RUN: begin
            if (mem_access_i) begin
               w_mem_req = 1'b1;
               if (!mem_ack_i) begin
                  w_mem_stall    = 1'b1;
                  w_state_nxt    = MEM_WAIT;
                  w_wait_cnt_nxt = '0;
               end
            end
         end
         MEM_WAIT: begin
            // mem_access_i is deliberately ignored here: the request is held to completion
            w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
            if (mem_ack_i) begin
               w_mem_req   = 1'b1;
               w_state_nxt = RUN;
            end else if (r_wait_cnt == TIMEOUT_LAST) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_mem_req   = 1'b1;
               w_mem_stall = 1'b1;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase

      w_ctrl.mem_req = w_mem_req;
      if (!rst_i) begin
         w_ctrl = CTRL_RESET;
      end else if (w_mem_stall) begin
         w_ctrl.pc_we        = 1'b0;
         w_ctrl.ifid_we      = 1'b0;
         w_ctrl.idex_we      = 1'b0;
         w_ctrl.exmem_we     = 1'b0;
         w_ctrl.memwb_bubble = 1'b1;
      end else if (w_load_use) begin
         // Branch flush is withheld; the branch resolves again next cycle
         w_ctrl.pc_we      = 1'b0;
         w_ctrl.ifid_we    = 1'b0;
         w_ctrl.idex_flush = 1'b1;
      end else if (branch_taken_i) begin
         w_ctrl.ifid_flush = 1'b1;
      end
   end

   assign mem_req_o      = w_ctrl.mem_req;
   assign pc_we_o        = w_ctrl.pc_we;
   assign ifid_we_o      = w_ctrl.ifid_we;
   assign ifid_flush_o   = w_ctrl.ifid_flush;
   assign idex_we_o      = w_ctrl.idex_we;
   assign idex_flush_o   = w_ctrl.idex_flush;
   assign exmem_we_o     = w_ctrl.exmem_we;
   assign memwb_bubble_o = w_ctrl.memwb_bubble;
   assign err_o          = r_err;

`ifdef PIPE_STALL_CTRL_PERF_EN
   logic [PERF_CNT_W-1:0] r_stall_cnt;
   logic [PERF_CNT_W-1:0] r_flush_cnt;

   // Saturating counts of PC-stall cycles and IF/ID flush cycles
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_ctrl.pc_we && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
         end
         if (w_ctrl.ifid_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + PERF_CNT_W'(1);
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max wait cycles for data-memory ack before abort (range 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, synchronous active-low reset).
REQ-003 Ports SHALL be:
- memread_ex_i  in  1  ID/EX instruction is a load.
- rd_ex_i  in  5  ID/EX destination register.
- rs1_id_i  in  5  IF/ID source 1.
- rs2_id_i  in  5  IF/ID source 2.
- branch_taken_i  in  1  branch resolved taken in ID.
- mem_access_i  in  1  EX/MEM instruction is load or store.
- mem_ack_i  in  1  data memory done.
- mem_req_o  out  1  data memory request.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID bubble.
- idex_we_o  out  1  ID/EX write enable.
- idex_flush_o  out  1  ID/EX bubble.
- exmem_we_o  out  1  EX/MEM write enable.
- memwb_bubble_o  out  1  MEM/WB loads RegWrite=0, MemtoReg=0.
- err_o  out  1  sticky memory-timeout flag.

Function
REQ-004 FSM states SHALL be RUN and MEM_WAIT; there is no other state.
REQ-005 RUN with mem_access_i=1: mem_req_o=1; if mem_ack_i=1 in the same cycle, there SHALL be no stall and the state SHALL stay RUN; otherwise the next state SHALL be MEM_WAIT.
REQ-006 MEM_WAIT: mem_req_o=1; pc_we_o, ifid_we_o, idex_we_o and exmem_we_o=0; memwb_bubble_o=1; on mem_ack_i=1, enables SHALL be released that cycle and the next state SHALL be RUN.
REQ-007 Wait counter (8 bit) SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; when it reaches TIMEOUT without ack, err_o SHALL be set (sticky until reset), mem_req_o SHALL drop, and the next state SHALL be RUN with enables released.
REQ-008 Load-use hazard SHALL be memread_ex_i=1 and rd_ex_i!=0 and (rd_ex_i==rs1_id_i or rd_ex_i==rs2_id_i); it SHALL give pc_we_o=0, ifid_we_o=0, idex_flush_o=1 for exactly that cycle.
REQ-009 Branch flush: branch_taken_i=1 SHALL give ifid_flush_o=1 for that cycle.
REQ-010 Priority SHALL be memory stall > load-use > branch; while memory-stalled, load-use and branch outputs SHALL be suppressed; load-use SHALL suppress ifid_flush_o in the same cycle, since the branch re-resolves next cycle.
REQ-011 With no event active, all enables SHALL be 1 and all flush/bubble outputs and mem_req_o SHALL be 0.
REQ-012 Control outputs SHALL be combinational from state and inputs, with zero-cycle latency; only state, the wait counter and err_o are registered.
REQ-013 mem_access_i deasserting in MEM_WAIT SHALL be ignored; the request SHALL be held until ack or timeout.

Reset
REQ-014 While rst_i=0 at a clock edge: state SHALL be RUN, wait counter 0, err_o 0.
REQ-015 While rst_i=0: all write enables and mem_req_o SHALL be 0, and ifid_flush_o, idex_flush_o and memwb_bubble_o SHALL be 1.
REQ-016 Reset asserted in MEM_WAIT SHALL abort the wait with no err_o.

Configuration
REQ-017 Macro PIPE_STALL_CTRL_PERF_EN defined: the block SHALL add outputs stall_cnt_o (32) and flush_cnt_o (32).
- stall_cnt_o counts cycles with pc_we_o=0 (memory stall or load-use).
- flush_cnt_o counts cycles with ifid_flush_o=1.
- Both saturate at 2^32-1 and clear on reset.
REQ-018 Macro undefined: these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-019 A shared package SHALL hold the state enum (RUN, MEM_WAIT), the register-index width constant (5) and the default TIMEOUT constant.
REQ-020 Hazard comparison SHALL be one sub-module, hazard_detect (combinational), instantiated once; FSM, counters and priority logic SHALL live in pipe_stall_ctrl.

Verification
REQ-021 The bench SHALL cover these scenarios:
- memread_ex_i=1, rd_ex_i=5, rs1_id_i=5 in RUN -> one cycle of pc_we_o=0, ifid_we_o=0, idex_flush_o=1; with rd_ex_i=0 -> no stall.
- mem_access_i=1, ack after 3 cycles -> mem_req_o high 4 cycles, exmem_we_o=0 for 3 cycles, memwb_bubble_o=1 for 3 cycles, then RUN.
- mem_access_i=1 with same-cycle ack -> no stall cycle, state stays RUN.
- TIMEOUT=4, never ack -> err_o=1 after 4 MEM_WAIT cycles, mem_req_o drops, enables return to 1, err_o stays 1 until rst_i=0.
- load-use and branch_taken_i together -> idex_flush_o=1, ifid_flush_o=0; branch_taken_i during MEM_WAIT -> ifid_flush_o=0.
- rst_i=0 mid-MEM_WAIT -> next state RUN, err_o=0; with PIPE_STALL_CTRL_PERF_EN, 3-cycle memory stall plus 1 load-use -> stall_cnt_o=4.
